// File: rtl/motor_pkg.sv
// motor_pkg: shared mode/state encodings and PWM constants for the dual H-bridge driver
package motor_pkg;
   typedef enum logic [1:0] {
      MODE_COAST = 2'b00,
      MODE_FWD   = 2'b01,
      MODE_REV   = 2'b10,
      MODE_BRAKE = 2'b11
   } mode_e;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DEAD   = 2'd2
   } state_e;
   localparam int         DUTY_SCALE = 17;
   localparam logic [7:0] PWM_TOP    = 8'd254;
endpackage

// File: rtl/hbridge_chan.sv
// hbridge_chan: one bridge side, mode FSM with dead-time on direct active-to-active changes
module hbridge_chan
   import motor_pkg::*;
#(
   parameter int DEAD_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] mode_i,
   input  logic       pwm_i,
   output logic       in1_o,
   output logic       in2_o,
   output logic       en_o,
   output logic       busy_o
);
   localparam int CW = $clog2(DEAD_CYCLES + 1);
   state_e          state_q, state_d;
   mode_e           mode_q, mode_d, req;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            in1_q, in2_q, en_q, busy_q;
   assign req = mode_e'(mode_i);
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: if (req != MODE_COAST) begin
            state_d = ST_ACTIVE;
            mode_d  = req;
         end
         ST_ACTIVE: if (req == MODE_COAST) begin
            state_d = ST_IDLE;
            mode_d  = MODE_COAST;
         end else if (req != mode_q) begin
            state_d = ST_DEAD;
            mode_d  = MODE_COAST;
            cnt_d   = CW'(DEAD_CYCLES - 1);
         end
         // only the request present on the exit cycle is applied
         ST_DEAD: if (cnt_q == '0) begin
            state_d = (req == MODE_COAST) ? ST_IDLE : ST_ACTIVE;
            mode_d  = req;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
         default: begin
            state_d = ST_IDLE;
            mode_d  = MODE_COAST;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_COAST;
         cnt_q   <= '0;
         in1_q   <= 1'b0;
         in2_q   <= 1'b0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         in1_q   <= mode_d[0];
         in2_q   <= mode_d[1];
         en_q    <= (mode_d == MODE_BRAKE) | ((mode_d != MODE_COAST) & pwm_i);
         busy_q  <= state_d == ST_DEAD;
      end
   end
   assign in1_o  = in1_q;
   assign in2_o  = in2_q;
   assign en_o   = en_q;
   assign busy_o = busy_q;
endmodule

// File: rtl/motor_drive.sv
// motor_drive: command register, shared PWM generator and two independent bridge channels
module motor_drive
   import motor_pkg::*;
#(
   parameter int PRESCALE    = 4,
   parameter int DEAD_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] cmd,
   output logic       in1_l,
   output logic       in2_l,
   output logic       en_l,
   output logic       in1_r,
   output logic       in2_r,
   output logic       en_r,
   output logic       busy_l,
   output logic       busy_r
);
   localparam int PW = $clog2(PRESCALE + 1);
   logic [7:0]    cmd_q, pwm_cnt_q, pwm_cnt_d, duty_q, duty_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          tick, wrap, pwm;
   assign tick = pre_q == PW'(PRESCALE - 1);
   assign wrap = tick && (pwm_cnt_q == PWM_TOP);
   // duty only changes at the period boundary so a period is never cut short
   always_comb begin
      pre_d     = tick ? '0 : pre_q + PW'(1);
      pwm_cnt_d = wrap ? '0 : pwm_cnt_q + 8'(tick);
      duty_d    = wrap ? {4'd0, cmd_q[7:4]} * 8'(DUTY_SCALE) : duty_q;
   end
   assign pwm = pwm_cnt_q < duty_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q     <= '0;
         pre_q     <= '0;
         pwm_cnt_q <= '0;
         duty_q    <= '0;
      end else begin
         cmd_q     <= cmd;
         pre_q     <= pre_d;
         pwm_cnt_q <= pwm_cnt_d;
         duty_q    <= duty_d;
      end
   end
   hbridge_chan #(.DEAD_CYCLES(DEAD_CYCLES)) u_left (
      .clk    (clk),
      .rst_n  (rst_n),
      .mode_i (cmd_q[1:0]),
      .pwm_i  (pwm),
      .in1_o  (in1_l),
      .in2_o  (in2_l),
      .en_o   (en_l),
      .busy_o (busy_l)
   );
   hbridge_chan #(.DEAD_CYCLES(DEAD_CYCLES)) u_right (
      .clk    (clk),
      .rst_n  (rst_n),
      .mode_i (cmd_q[3:2]),
      .pwm_i  (pwm),
      .in1_o  (in1_r),
      .in2_o  (in2_r),
      .en_o   (en_r),
      .busy_o (busy_r)
   );
endmodule

// File: tb/tb_motor_drive.sv
// tb_motor_drive: directed scenarios plus random commands, checked against a cycle-level reference model
module tb_motor_drive;
   localparam int P = 1;
   localparam int D = 8;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] cmd = 8'h00;
   logic       in1_l, in2_l, en_l, in1_r, in2_r, en_r, busy_l, busy_r;
   logic [7:0] outs;
   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   always #5 clk = ~clk;
   motor_drive #(.PRESCALE(P), .DEAD_CYCLES(D)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .cmd    (cmd),
      .in1_l  (in1_l),
      .in2_l  (in2_l),
      .en_l   (en_l),
      .in1_r  (in1_r),
      .in2_r  (in2_r),
      .en_r   (en_r),
      .busy_l (busy_l),
      .busy_r (busy_r)
   );
   assign outs = {in1_l, in2_l, en_l, busy_l, in1_r, in2_r, en_r, busy_r};
   // Reference model: e counts clock edges since reset; side state is applied mode plus remaining busy cycles.
   int         e;
   int         duty;
   int         am[2];
   int         dr[2];
   int         r;
   logic [7:0] mcmd;
   logic [7:0] ex;
   bit         pwm_m;
   function automatic logic [3:0] side_out(input int a, input int d, input bit p);
      int m;
      m = (d > 0) ? 0 : a;
      return {m == 1 || m == 3, m == 2 || m == 3, m == 3 || ((m == 1 || m == 2) && p), d > 0};
   endfunction
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e = 0;
         duty = 0;
         mcmd = 8'h00;
         am[0] = 0; am[1] = 0;
         dr[0] = 0; dr[1] = 0;
         exp_q.delete();
      end else begin
         pwm_m = ((e / P) % 255) < duty;
         for (int s = 0; s < 2; s++) begin
            r = (int'(mcmd) >> (2 * s)) & 3;
            if (dr[s] > 0) begin
               if (dr[s] == 1) begin
                  dr[s] = 0;
                  am[s] = r;
               end else dr[s] = dr[s] - 1;
            end else if (am[s] != 0 && r != 0 && r != am[s]) begin
               dr[s] = D;
               am[s] = 0;
            end else am[s] = r;
         end
         ex = {side_out(am[0], dr[0], pwm_m), side_out(am[1], dr[1], pwm_m)};
         exp_q.push_back(ex);
         if ((e + 1) % (255 * P) == 0) duty = 17 * (int'(mcmd) >> 4);
         mcmd = cmd;
         e = e + 1;
      end
   end
   logic [7:0] got;
   always @(negedge clk) begin
      if (rst_n && exp_q.size() > 0) begin
         got = exp_q.pop_front();
         n_vec++;
         if (outs !== got) begin
            n_err++;
            $display("FAIL scoreboard t=%0t actual=%b required=%b", $time, outs, got);
         end
      end
   end
   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask
   task automatic count_hi(input int sel, input int n, output int c);
      c = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         c += (sel == 0) ? int'(en_l) : (sel == 1) ? int'(en_r) : (sel == 2) ? int'(busy_l) : int'(busy_r);
      end
   endtask
   int c;
   initial begin
      repeat (3) @(negedge clk);
      check("reset_outputs", int'(outs), 0);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      check("idle_outputs", int'(outs), 0);
      cmd = 8'h85;
      @(negedge clk);
      check("fwd_latency_early", int'({in1_l, in2_l, in1_r, in2_r}), 0);
      @(negedge clk);
      check("fwd_latency", int'({in1_l, in2_l, in1_r, in2_r}), 4'b1010);
      repeat (600) @(negedge clk);
      count_hi(0, 255, c);
      check("duty8_left", c, 136);
      count_hi(1, 255, c);
      check("duty8_right", c, 136);
      cmd = 8'hF5;
      repeat (600) @(negedge clk);
      cmd = 8'hFA;
      count_hi(2, 20, c);
      check("dead_len_left", c, D);
      check("rev_left", int'({in1_l, in2_l, en_l}), 3'b011);
      check("rev_right", int'({in1_r, in2_r, en_r}), 3'b011);
      cmd = 8'hF5;
      repeat (20) @(negedge clk);
      cmd = 8'hF7;
      c = 0;
      begin
         int cr;
         cr = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 1) cmd = 8'hF6;
            if (i == 2) cmd = 8'hF7;
            c += int'(busy_l);
            cr += int'(busy_r);
         end
         check("dead_no_restart", c, D);
         check("right_unaffected_busy", cr, 0);
      end
      check("brake_left", int'({in1_l, in2_l, en_l}), 3'b111);
      check("fwd_right", int'({in1_r, in2_r, en_r}), 3'b101);
      cmd = 8'hF5;
      repeat (20) @(negedge clk);
      cmd = 8'hF0;
      @(negedge clk);
      cmd = 8'hFA;
      count_hi(2, 10, c);
      check("coast_path_no_dead", c, 0);
      check("coast_path_rev", int'({in1_l, in2_l, en_l}), 3'b011);
      cmd = 8'hF5;
      repeat (20) @(negedge clk);
      cmd = 8'hFA;
      repeat (5) @(negedge clk);
      check("dead_before_reset", int'(busy_l), 1);
      #2 rst_n = 1'b0;
      #1 check("async_reset", int'(outs), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      count_hi(2, 10, c);
      check("post_reset_no_dead", c, 0);
      check("post_reset_rev", int'({in1_l, in2_l}), 2'b01);
      for (int i = 0; i < 300; i++) begin
         cmd = 8'($urandom);
         repeat ($urandom_range(1, 15)) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
